// File: rtl/seven_divider_ctrl.sv
// ----------------------------------------------------------------------------
// seven_divider_ctrl
//
// Unsigned 7-bit restoring divider controller. It shares one external
// combinational seven_subtractor and issues one trial subtraction per cycle.
// A start/done handshake returns quotient and remainder after 8 cycles; a
// zero divisor returns after 2 cycles with the div_by_zero flag set.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   start        request, sampled only in IDLE
//   dividend     7-bit unsigned dividend, sampled on the accepting edge
//   divisor      7-bit unsigned divisor, sampled on the accepting edge
//   sub_a        subtractor operand a (trial value), zero outside CALC
//   sub_b        subtractor operand b (divisor), zero outside CALC
//   sub_diff     subtractor result, 14-bit sign-extended a-b
//   busy         high in CALC and DONE
//   done         one-cycle pulse, results valid while high
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered flag, updated together with done
//   state_dbg    current FSM state (0=IDLE, 1=CALC, 2=DONE)
//
// Handshake: start is sampled only while busy is low; a request seen in CALC
// or DONE is dropped, not queued. done is high for exactly one cycle and the
// result outputs are already valid in that cycle.
// ----------------------------------------------------------------------------
module seven_divider_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  dividend,
    input  logic [6:0]  divisor,
    output logic [6:0]  sub_a,
    output logic [6:0]  sub_b,
    input  logic [13:0] sub_diff,
    output logic        busy,
    output logic        done,
    output logic [6:0]  quotient,
    output logic [6:0]  remainder,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [6:0]  q_reg;     // dividend shift register, collects quotient bits
    logic [6:0]  d_reg;     // divisor
    logic [6:0]  r_reg;     // partial remainder
    logic [2:0]  count;     // bit index of the current step
    logic        dz_pend;   // divide-by-zero result waiting in q_reg/r_reg

    logic [6:0]  trial;
    logic        ovf;
    logic        borrow;
    logic        take;
    logic [6:0]  r_step;
    logic [6:0]  q_step;

    // One restoring step. The subtractor result is sign-extended, so any set
    // bit above bit 6 means the trial subtraction went negative.
    always_comb begin
        trial  = {r_reg[5:0], q_reg[6]};
        ovf    = r_reg[6];
        borrow = |sub_diff[13:7];
        // With ovf set the true trial is 128+trial >= divisor, so the
        // subtraction always succeeds and its low 7 bits are exact.
        take   = ovf | ~borrow;
        r_step = take ? sub_diff[6:0] : trial;
        q_step = {q_reg[5:0], take};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero divisor still passes through one CALC cycle
    // (with the step suppressed) so that done arrives 2 cycles after accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == 3'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        sub_a     = 7'd0;
        sub_b     = 7'd0;
        state_dbg = state;
        case (state)
            CALC: begin
                busy = 1'b1;
                if (!dz_pend) begin
                    sub_a = trial;
                    sub_b = d_reg;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg       <= 7'd0;
            d_reg       <= 7'd0;
            r_reg       <= 7'd0;
            count       <= 3'd0;
            dz_pend     <= 1'b0;
            quotient    <= 7'd0;
            remainder   <= 7'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 7'd0) begin
                            q_reg   <= dividend;
                            d_reg   <= divisor;
                            r_reg   <= 7'd0;
                            count   <= 3'd6;
                            dz_pend <= 1'b0;
                        end else begin
                            q_reg   <= 7'h7F;
                            d_reg   <= 7'd0;
                            r_reg   <= dividend;
                            count   <= 3'd0;
                            dz_pend <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!dz_pend) begin
                        q_reg <= q_step;
                        r_reg <= r_step;
                    end
                    if (count == 3'd0) begin
                        // Publish on entry to DONE so results are valid
                        // in the done cycle itself.
                        quotient    <= dz_pend ? q_reg : q_step;
                        remainder   <= dz_pend ? r_reg : r_step;
                        div_by_zero <= dz_pend;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
